// File: rtl/slave_model_pkg.sv
// Shared types and constants for the read-responder slave model and its queue.
package slave_model_pkg;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  localparam int TS_W = 16;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [TS_W-1:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [31:0]     addr;
    logic [TS_W-1:0] ts;
  } rd_entry;

endpackage

// File: rtl/slave_rd_responder_fifo.sv
// First-word-fall-through queue; the head word is visible on pop_data while not empty.
module slave_rd_responder_fifo #(
  parameter int B = 48,
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic [B-1:0] push_data,
  input  logic         pop,
  output logic [B-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam logic [W:0] PTR_ONE = {{W{1'b0}}, 1'b1};

  logic [B-1:0] mem [2**W];
  logic [W:0]   wr_ptr_reg;
  logic [W:0]   rd_ptr_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg[W-1:0]] <= push_data;
  end

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign pop_data = mem[rd_ptr_reg[W-1:0]];
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[W] != rd_ptr_reg[W]) &&
                    (wr_ptr_reg[W-1:0] == rd_ptr_reg[W-1:0]);

endmodule

// File: rtl/slave_rd_responder.sv
// Slave model: acks requests, answers reads in order with rdata = addr after LATENCY cycles.
// Optional random ack throttling when SLAVE_RD_RESPONDER_ACK_RANDOM_EN is defined.
module slave_rd_responder
  import slave_model_pkg::*;
#(
  parameter int              SNUM      = 0,
  parameter int              W         = 3,
  parameter int              LATENCY   = 4,
  parameter logic [TS_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        slave_req,
  input  logic [31:0] slave_addr,
  input  logic        slave_cmd,
  input  logic [31:0] slave_wdata,
  output logic        slave_ack,
  output logic [31:0] slave_rdata,
  output logic        slave_resp,
  output logic [W:0]  rd_outstanding
);

  localparam logic [TS_W-1:0] LAT     = TS_W'(LATENCY);
  localparam logic [TS_W-1:0] TS_ONE  = TS_W'(1);
  localparam logic [W:0]      OUT_ONE = {{W{1'b0}}, 1'b1};

  logic            full;
  logic            empty;
  logic            gate;
  logic            push;
  logic            pop;
  logic [47:0]     head_bits;
  rd_entry         head;
  rd_entry         entry_in;
  logic [TS_W-1:0] cnt_reg;
  logic [TS_W-1:0] age;
  logic            unused_bits;

`ifdef SLAVE_RD_RESPONDER_ACK_RANDOM_EN
  logic [TS_W-1:0] lfsr_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_reg <= LFSR_SEED;
    else       lfsr_reg <= {1'b0, lfsr_reg[TS_W-1:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : '0);
  end

  assign gate        = lfsr_reg[0] | lfsr_reg[1];
  assign unused_bits = ^slave_wdata;
`else
  assign gate        = 1'b1;
  assign unused_bits = ^{slave_wdata, LFSR_SEED};
`endif

  assign slave_ack = slave_req & ~full & gate & ~rst_i;
  assign push      = slave_ack & (slave_cmd == CMD_RD);

  assign entry_in.addr = slave_addr;
  assign entry_in.ts   = cnt_reg;
  assign head          = rd_entry'(head_bits);

  // Age is measured at the cycle the response becomes visible, so a read
  // accepted in cycle T is answered in cycle T+LATENCY.
  assign age = cnt_reg + TS_ONE - head.ts;
  assign pop = ~empty & ~rst_i & (age >= LAT);

  slave_rd_responder_fifo #(
    .B (48),
    .W (W)
  ) u_queue (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push),
    .push_data (entry_in),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg        <= '0;
      slave_resp     <= 1'b0;
      slave_rdata    <= '0;
      rd_outstanding <= '0;
    end else begin
      cnt_reg    <= cnt_reg + TS_ONE;
      slave_resp <= pop;
      if (pop) slave_rdata <= head.addr;
      if (push && !pop)      rd_outstanding <= rd_outstanding + OUT_ONE;
      else if (!push && pop) rd_outstanding <= rd_outstanding - OUT_ONE;
    end
  end

  // Protocol checks: the master must hold req until it is acked.
  req_held_a: assert property (@(posedge clk_i) disable iff (rst_i)
      (slave_req && !slave_ack) |=> slave_req)
    else $fatal(1, "slave_rd_responder[%0d]: req dropped before ack", SNUM);

  pop_nonempty_a: assert property (@(posedge clk_i) disable iff (rst_i)
      pop |-> !empty)
    else $fatal(1, "slave_rd_responder[%0d]: pop from empty queue", SNUM);

endmodule

// File: tb/tb_slave_rd_responder.sv
// Self-checking bench: cycle-level queue model of the responder plus directed literal checks.
module tb_slave_rd_responder;
  import slave_model_pkg::*;

  localparam int W     = 3;
  localparam int DEPTH = 2**W;
  localparam int LAT   = 10;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        slave_req = 1'b0;
  logic [31:0] slave_addr = '0;
  logic        slave_cmd = 1'b0;
  logic [31:0] slave_wdata = '0;
  logic        slave_ack;
  logic [31:0] slave_rdata;
  logic        slave_resp;
  logic [W:0]  rd_outstanding;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  slave_rd_responder #(
    .SNUM      (0),
    .W         (W),
    .LATENCY   (LAT),
    .LFSR_SEED (SEED)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .slave_req      (slave_req),
    .slave_addr     (slave_addr),
    .slave_cmd      (slave_cmd),
    .slave_wdata    (slave_wdata),
    .slave_ack      (slave_ack),
    .slave_rdata    (slave_rdata),
    .slave_resp     (slave_resp),
    .rd_outstanding (rd_outstanding)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: pending reads with the cycle their response is due.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } ent_t;
  ent_t        mq[$];
  logic        exp_resp = 1'b0;
  logic [31:0] exp_rdata = '0;
  int          exp_out = 0;
  logic [15:0] lfsr = SEED;
  bit          mvalid = 1'b0;

  always @(negedge clk_i) begin
    logic gate;
    logic e_ack;
    if (rst_i) begin
      chk("ack_in_reset", slave_ack, 0);
      mq.delete();
      exp_resp  = 1'b0;
      exp_rdata = '0;
      exp_out   = 0;
      lfsr      = SEED;
      mvalid    = 1'b1;
    end else if (mvalid) begin
`ifdef SLAVE_RD_RESPONDER_ACK_RANDOM_EN
      gate = lfsr[0] | lfsr[1];
`else
      gate = 1'b1;
`endif
      e_ack = slave_req && (mq.size() < DEPTH) && gate;
      chk("ack", slave_ack, e_ack);
      chk("resp", slave_resp, exp_resp);
      chk("rdata", slave_rdata, exp_rdata);
      chk("rd_outstanding", rd_outstanding, exp_out);
      exp_resp = (mq.size() > 0) && (mq[0].due <= cyc + 1);
      if (exp_resp) exp_rdata = mq.pop_front().addr;
      if (e_ack && slave_cmd == CMD_RD) mq.push_back('{slave_addr, cyc + LAT});
      exp_out = mq.size();
      lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Response log and occupancy peak for the directed literal checks.
  typedef struct {
    int          c;
    logic [31:0] d;
  } rsp_t;
  rsp_t resp_log[$];
  int   peak = 0;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (slave_resp) resp_log.push_back('{cyc, slave_rdata});
      if (int'(rd_outstanding) > peak) peak = int'(rd_outstanding);
    end
  end

  // Starts at posedge+1, holds req until acked, returns at posedge+1 after the ack cycle.
  task automatic do_req(input logic c, input logic [31:0] a, output int t_ack);
    bit got = 1'b0;
    t_ack       = -1;
    slave_req   = 1'b1;
    slave_cmd   = c;
    slave_addr  = a;
    slave_wdata = $urandom;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_i);
      if (slave_ack) begin
        got   = 1'b1;
        t_ack = cyc;
      end
      @(posedge clk_i);
      #1;
    end
    slave_req = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: addr 0x%0h not acked within 100 cycles", a);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    int t[9];
    int ta;
    int tw;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    idle(2);

    // Single read.
    resp_log.delete();
    do_req(CMD_RD, 32'h0000_1000, t[0]);
    chk("t1_outstanding_1", rd_outstanding, 1);
    idle(LAT + 3);
    chk("t1_resp_count", resp_log.size(), 1);
    if (resp_log.size() >= 1) begin
      chk("t1_latency", resp_log[0].c - t[0], LAT);
      chk("t1_rdata", resp_log[0].d, 32'h0000_1000);
    end
    chk("t1_outstanding_0", rd_outstanding, 0);

    // Back-to-back reads.
    resp_log.delete();
    do_req(CMD_RD, 32'h10, t[0]);
    do_req(CMD_RD, 32'h20, t[1]);
    do_req(CMD_RD, 32'h30, t[2]);
    idle(LAT + 5);
    chk("t2_resp_count", resp_log.size(), 3);
    if (resp_log.size() >= 3) begin
      chk("t2_rdata0", resp_log[0].d, 32'h10);
      chk("t2_rdata1", resp_log[1].d, 32'h20);
      chk("t2_rdata2", resp_log[2].d, 32'h30);
      chk("t2_gap01", resp_log[1].c - resp_log[0].c, 1);
      chk("t2_gap12", resp_log[2].c - resp_log[1].c, 1);
    end

    // Fill the queue: ninth read waits for the first pop.
    peak = 0;
    resp_log.delete();
    for (int i = 0; i < 9; i++) do_req(CMD_RD, 32'h100 + 32'(i), t[i]);
`ifndef SLAVE_RD_RESPONDER_ACK_RANDOM_EN
    chk("t3_eighth_ack", t[7] - t[0], 7);
    chk("t3_ninth_ack", t[8] - t[0], LAT);
`endif
    idle(2 * LAT + 10);
    chk("t3_peak", peak, 8);
    chk("t3_resp_count", resp_log.size(), 9);
    if (resp_log.size() >= 9) chk("t3_last_rdata", resp_log[8].d, 32'h108);

    // Write between two reads.
    resp_log.delete();
    do_req(CMD_RD, 32'h50, t[0]);
    do_req(CMD_WR, 32'h40, tw);
    do_req(CMD_RD, 32'h60, t[1]);
    chk("t4_write_acked", tw > t[0], 1);
    idle(LAT + 5);
    chk("t4_resp_count", resp_log.size(), 2);
    if (resp_log.size() >= 2) begin
      chk("t4_rdata0", resp_log[0].d, 32'h50);
      chk("t4_rdata1", resp_log[1].d, 32'h60);
    end

    // Reset flushes a pending read.
    resp_log.delete();
    do_req(CMD_RD, 32'h70, t[0]);
    idle(1);
    rst_i = 1'b1;
    idle(2);
    rst_i = 1'b0;
    idle(LAT + 5);
    chk("t5_no_resp", resp_log.size(), 0);
    chk("t5_outstanding", rd_outstanding, 0);
    do_req(CMD_RD, 32'h80, ta);
    idle(LAT + 3);
    chk("t5_resp_count", resp_log.size(), 1);
    if (resp_log.size() >= 1) begin
      chk("t5_rdata", resp_log[0].d, 32'h80);
      chk("t5_latency", resp_log[0].c - ta, LAT);
    end

    // Random traffic checked by the model every cycle.
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 2) == 0 ? 1 : 0);
      do_req(($urandom_range(0, 3) == 0) ? CMD_WR : CMD_RD, $urandom, ta);
    end
    idle(LAT + 10);
    chk("final_outstanding", rd_outstanding, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
